// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the PC / instruction-fetch front end.
package pc_fetch_ctrl_pkg;

  localparam int PCSIZE = 32;
  localparam logic [PCSIZE-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_ISSUE = 2'd2,
    FS_ERR   = 2'd3
  } fetch_state_e;

  // A fetch address is legal only when word-aligned.
  function automatic logic is_misaligned(input logic [PCSIZE-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between fetch control and imem.
// Handshake: imem_req stays high with a stable imem_addr until the edge on which
// imem_ack is high; imem_rdata is consumed on that same edge, and ack is ignored
// whenever imem_req is low.
interface pc_fetch_ctrl_if;
  import pc_fetch_ctrl_pkg::*;

  logic              imem_req;
  logic [PCSIZE-1:0] imem_addr;
  logic              imem_ack;
  logic [PCSIZE-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl_next_pc_sel.sv
// Next-PC priority mux: jump over taken branch over the sequential PC4 value,
// plus an alignment flag on the selected address.
module pc_fetch_ctrl_next_pc_sel
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [PCSIZE-1:0] pc4_i,
  input  logic              branch_taken_i,
  input  logic [PCSIZE-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [PCSIZE-1:0] jump_target_i,
  output logic [PCSIZE-1:0] npc_o,
  output logic              npc_misaligned_o
);

  always_comb begin
    npc_o = pc4_i;
    if (jump_i) begin
      npc_o = jump_target_i;
    end else if (branch_taken_i) begin
      npc_o = branch_target_i;
    end
  end

  assign npc_misaligned_o = is_misaligned(npc_o);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer: IDLE -> REQ -> ISSUE -> REQ ...,
// with a sticky ERR state entered when the selected next PC is not word-aligned.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [PCSIZE-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PCSIZE-1:0] PC4,
  input  logic              branch_taken,
  input  logic [PCSIZE-1:0] branch_target,
  input  logic              jump,
  input  logic [PCSIZE-1:0] jump_target,
  input  logic              stall,
  pc_fetch_ctrl_if.master   imem,
  output logic [PCSIZE-1:0] PC,
  output logic [PCSIZE-1:0] instr,
  output logic              instr_valid,
  output logic              misalign,
  output fetch_state_e      state_o
);

  fetch_state_e      state_q, state_d;
  logic [PCSIZE-1:0] pc_q, pc_d;
  logic [PCSIZE-1:0] instr_q, instr_d;
  logic              misalign_q, misalign_d;
  logic [PCSIZE-1:0] npc;
  logic              npc_misaligned;

  pc_fetch_ctrl_next_pc_sel u_next_pc_sel (
    .pc4_i            (PC4),
    .branch_taken_i   (branch_taken),
    .branch_target_i  (branch_target),
    .jump_i           (jump),
    .jump_target_i    (jump_target),
    .npc_o            (npc),
    .npc_misaligned_o (npc_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

  // Branch/jump inputs only matter in ISSUE without stall; ack only in REQ.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = FS_ISSUE;
        end
      end
      FS_ISSUE: begin
        if (!stall) begin
          if (npc_misaligned) begin
            misalign_d = 1'b1;
            state_d    = FS_ERR;
          end else begin
            pc_d    = npc;
            state_d = FS_REQ;
          end
        end
      end
      FS_ERR:  state_d = FS_ERR;
      default: state_d = FS_IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == FS_REQ);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == FS_ISSUE);
  assign PC             = pc_q;
  assign instr          = instr_q;
  assign misalign       = misalign_q;
  assign state_o        = state_q;

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter register and instruction-fetch sequencer for the CPU front end. Holds the architectural PC, drives it to the PC+4 adder (`pcAlu`) and to instruction memory, and runs a request/acknowledge handshake with instruction memory. It presents each fetched instruction to decode and selects the next PC from the sequential value (`PC4`, returned by `pcAlu`), a branch target or a jump target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word-aligned.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `PC4` in 32: sequential next PC, returned by `pcAlu`.
- `branch_taken` in 1: conditional branch resolved taken; sampled only in ISSUE.
- `branch_target` in 32: branch destination.
- `jump` in 1: unconditional jump/jr; sampled only in ISSUE.
- `jump_target` in 32: jump destination.
- `stall` in 1: downstream not ready; holds the current instruction.
- `imem_ack` in 1: instruction memory has `imem_rdata` valid this cycle.
- `imem_rdata` in 32: instruction word.
- `PC` out 32: current PC register; feeds `pcAlu` and decode.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals `PC`.
- `instr` out 32: latched instruction.
- `instr_valid` out 1: `instr` is valid for the current `PC`.
- `misalign` out 1: sticky fault; the selected next PC had bits [1:0] ≠ 0.

## Operation
- States:
  - IDLE: first cycle after reset.
  - REQ: request outstanding.
  - ISSUE: instruction presented.
  - ERR: fault.
- IDLE → REQ unconditionally on the next edge.
- REQ:
  - `imem_req` = 1.
  - Stays in REQ while `imem_ack` = 0. There is no timeout.
  - On an edge with `imem_ack` = 1: latch `imem_rdata` into `instr` and go to ISSUE.
- ISSUE:
  - `instr_valid` = 1 and `imem_req` = 0.
  - If `stall` = 1: PC, `instr` and state are all held. `branch_taken` and `jump` are ignored.
  - If `stall` = 0: compute next PC with priority `jump` > `branch_taken` > sequential (`jump_target` / `branch_target` / `PC4`).
    - If next PC[1:0] = 0: PC ← next PC and state → REQ.
    - Otherwise: PC is unchanged, state → ERR and `misalign` ← 1.
- ERR:
  - All outputs hold; `imem_req` = 0, `instr_valid` = 0, `misalign` = 1.
  - Only reset leaves ERR.
- `imem_ack` outside REQ is ignored. It does not change `instr` or state.
- `jump` and `branch_taken` both high: jump wins.
- Arithmetic: no addition is done here. `PC4` wraps modulo 2^32 upstream, so a PC of 32'hFFFF_FFFC followed by a sequential step gives PC = 0 with no fault.

## Timing
- Reset values, on an edge with `rst_n` = 0:
  - PC = `RESET_PC`, `instr` = 0, state = IDLE.
  - `imem_req` = 0, `instr_valid` = 0, `misalign` = 0.
- Reset mid-request: `imem_req` drops on that edge, and any ack in the same cycle is discarded.
- After `rst_n` rises: IDLE for 1 cycle, then `imem_req` = 1 from the 2nd cycle.
- Fetch latency: `instr_valid` rises on the cycle after the ack edge.
- Best-case throughput: 2 cycles per instruction (REQ with immediate ack, then ISSUE with no stall).
- All outputs are registered, except `imem_addr` (a wire from `PC`) and `imem_req` / `instr_valid` (decoded from the state register only).
- PC update happens on the ISSUE→REQ edge. The new `imem_addr` is valid in the same cycle that `imem_req` rises.

## Structure
- `defines.vh` holds:
  - `PCSIZE`.
  - `` `RESET_PC_DEFAULT ``.
  - 2-bit state encodings: `` `FS_IDLE=0 ``, `` `FS_REQ=1 ``, `` `FS_ISSUE=2 ``, `` `FS_ERR=3 ``.
- One combinational sub-module, `next_pc_sel`: inputs are the priority mux operands; outputs are `npc` and `npc_misaligned`.
- `pcAlu` stays external; it connects `PC` → `PC4`.

## Test plan
- Reset with `RESET_PC` = 32'h0000_3000 and ack returned 1 cycle after `imem_req` → `imem_addr` = 3000, then 3004, then 3008; `instr_valid` is high every 3rd cycle.
- In ISSUE, assert `jump` = 1 (`jump_target` = 32'h0000_4000) together with `branch_taken` = 1 (`branch_target` = 32'h0000_5000) → next `imem_addr` = 4000.
- Assert `stall` for 4 cycles in ISSUE while pulsing `branch_taken` → PC and `instr` are unchanged; after release the next address is PC+4.
- `branch_target` = 32'h0000_3002 with `branch_taken` = 1 → `misalign` = 1 the next cycle and `imem_req` stays 0 for 20 cycles; only `rst_n` = 0 clears the fault.
- Pull `rst_n` low while in REQ and assert `imem_ack` on the same edge → `instr` = 0, `instr_valid` = 0, PC = `RESET_PC`. A spurious ack later in IDLE is ignored.
- PC = 32'hFFFF_FFFC with a sequential step → PC = 0 and `misalign` stays 0.
